// File: rtl/preg_alloc_ctrl_pkg.sv
// Shared sizing, types and helpers for the physical-register free-list controller.
package preg_alloc_ctrl_pkg;

    localparam int NUM_PREGS              = 64;
    localparam int NUM_AREGS              = 16;
    localparam int MAX_PREDICT_DEPTH_BITS = 2;

    localparam int PREG_W      = $clog2(NUM_PREGS);
    localparam int PTR_W       = PREG_W + 1;
    localparam int NUM_CKPT    = 2 ** MAX_PREDICT_DEPTH_BITS;
    localparam int INIT_CYCLES = (NUM_PREGS - NUM_AREGS) / 2;
    localparam int INIT_CNT_W  = $clog2(INIT_CYCLES);

    typedef logic [PREG_W-1:0]               preg_t;
    typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] branch_tag_t;
    typedef logic [PTR_W-1:0]                ptr_t;      // list pointer with wrap bit
    typedef logic [MAX_PREDICT_DEPTH_BITS:0] ckpt_ptr_t; // checkpoint pointer with wrap bit

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/preg_alloc_ctrl_if.sv
// Rename/commit-facing bundle of the free-list controller.
interface preg_alloc_ctrl_if;
    import preg_alloc_ctrl_pkg::*;

    logic        ready;
    logic [1:0]  alloc_req;
    logic        alloc_branch;
    logic        alloc_grant;
    preg_t       alloc_preg1;
    preg_t       alloc_preg2;
    branch_tag_t alloc_tag;
    logic        ckpt_full;
    ptr_t        num_free;
    logic [1:0]  free_valid;
    preg_t       free_preg1;
    preg_t       free_preg2;
    logic        resolve;
    logic        shootdown;
    branch_tag_t shootdown_tag;

    modport master (
        input  ready, alloc_grant, alloc_preg1, alloc_preg2, alloc_tag, ckpt_full, num_free,
        output alloc_req, alloc_branch, free_valid, free_preg1, free_preg2,
               resolve, shootdown, shootdown_tag
    );

    modport slave (
        output ready, alloc_grant, alloc_preg1, alloc_preg2, alloc_tag, ckpt_full, num_free,
        input  alloc_req, alloc_branch, free_valid, free_preg1, free_preg2,
               resolve, shootdown, shootdown_tag
    );

endinterface

// File: rtl/preg_alloc_ctrl_freelist_ckpt_table.sv
// Per-branch snapshots of the allocation head, with in-order tag allocation,
// oldest-first release and shootdown truncation of younger checkpoints.
module freelist_ckpt_table
    import preg_alloc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        branch_grant,
    input  ptr_t        branch_head,
    input  logic        resolve,
    input  logic        shootdown,
    input  branch_tag_t shootdown_tag,
    output branch_tag_t alloc_tag,
    output logic        ckpt_full,
    output ptr_t        restore_head
);

    ckpt_ptr_t          a_ptr, o_ptr, a_nxt, o_eff;
    logic [NUM_CKPT-1:0] valid, valid_nxt;
    ptr_t               ckpt_head [NUM_CKPT];
    branch_tag_t        a_tag, o_tag, o_eff_tag, shoot_dist;

    assign a_tag        = a_ptr[MAX_PREDICT_DEPTH_BITS-1:0];
    assign o_tag        = o_ptr[MAX_PREDICT_DEPTH_BITS-1:0];
    assign o_eff_tag    = o_eff[MAX_PREDICT_DEPTH_BITS-1:0];
    assign alloc_tag    = a_tag;
    assign ckpt_full    = ((a_ptr - o_ptr) == ckpt_ptr_t'(NUM_CKPT));
    assign restore_head = ckpt_head[shootdown_tag];
    assign shoot_dist   = shootdown_tag - o_eff_tag;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        a_nxt     = a_ptr;
        o_eff     = o_ptr;
        valid_nxt = valid;
        // A same-cycle resolve retires the oldest entry before the shootdown truncates.
        if (resolve) begin
            valid_nxt[o_tag] = 1'b0;
            o_eff            = o_ptr + ckpt_ptr_t'(1);
        end
        if (shootdown) begin
            a_nxt = {o_eff[MAX_PREDICT_DEPTH_BITS] ^ (shootdown_tag < o_eff_tag), shootdown_tag};
            for (int j = 0; j < NUM_CKPT; j++) begin
                if (branch_tag_t'(branch_tag_t'(j) - o_eff_tag) >= shoot_dist)
                    valid_nxt[j] = 1'b0;
            end
        end else if (branch_grant) begin
            valid_nxt[a_tag] = 1'b1;
            a_nxt            = a_ptr + ckpt_ptr_t'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_ptr <= '0;
            o_ptr <= '0;
            valid <= '0;
        end else begin
            a_ptr <= a_nxt;
            o_ptr <= o_eff;
            valid <= valid_nxt;
        end
    end

    // NOTE: snapshot storage is left unreset; an entry is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (branch_grant && !shootdown)
            ckpt_head[a_tag] <= branch_head;
    end

    a_resolve_live: assert property (@(posedge clk) disable iff (!reset_n)
        resolve |-> valid[o_tag]);

    a_shootdown_live: assert property (@(posedge clk) disable iff (!reset_n)
        shootdown |-> (valid[shootdown_tag] && !(resolve && shootdown_tag == o_tag)));

endmodule

// File: rtl/preg_alloc_ctrl.sv
// Physical-register free list: all-or-nothing 2-wide allocation, 2-wide frees,
// branch checkpoints of the head pointer, and a post-reset fill sequence.
module preg_alloc_ctrl
    import preg_alloc_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    preg_alloc_ctrl_if.slave  bus
);

    state_t                state, state_nxt;
    logic [INIT_CNT_W-1:0] init_cnt;
    ptr_t                  head, tail, num_free, restore_head;
    preg_t                 list_mem [NUM_PREGS];
    preg_t                 head_idx, tail_idx;
    logic                  run, grant;
    logic [1:0]            free_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_INIT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        run       = 1'b0;
        case (state)
            ST_INIT: if (init_cnt == INIT_CNT_W'(INIT_CYCLES - 1)) state_nxt = ST_RUN;
            ST_RUN:  run = 1'b1;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign head_idx = head[PREG_W-1:0];
    assign tail_idx = tail[PREG_W-1:0];
    assign num_free = tail - head;
    assign free_cnt = popcount2(bus.free_valid);

    // Grant is judged on the current occupancy only; same-cycle frees are not bypassed.
    assign grant = run && !bus.shootdown && (num_free >= ptr_t'(bus.alloc_req))
                   && !(bus.alloc_branch && bus.ckpt_full);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head     <= '0;
            tail     <= '0;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            tail     <= tail + ptr_t'(2);
            init_cnt <= init_cnt + INIT_CNT_W'(1);
        end else begin
            tail <= tail + ptr_t'(free_cnt);
            if (bus.shootdown)
                head <= restore_head;
            else if (grant)
                head <= head + ptr_t'(bus.alloc_req);
        end
    end

    // The fill writes entry i = NUM_AREGS+i; frees pack into consecutive tail slots.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            list_mem[tail_idx]                <= preg_t'(NUM_AREGS) + tail_idx;
            list_mem[tail_idx + preg_t'(1)]   <= preg_t'(NUM_AREGS) + tail_idx + preg_t'(1);
        end else begin
            if (bus.free_valid[0])
                list_mem[tail_idx] <= bus.free_preg1;
            if (bus.free_valid[1])
                list_mem[tail_idx + preg_t'(bus.free_valid[0])] <= bus.free_preg2;
        end
    end

    freelist_ckpt_table u_ckpt (
        .clk           (clk),
        .reset_n       (reset_n),
        .branch_grant  (grant && bus.alloc_branch),
        .branch_head   (head + ptr_t'(bus.alloc_req)),
        .resolve       (run && bus.resolve),
        .shootdown     (run && bus.shootdown),
        .shootdown_tag (bus.shootdown_tag),
        .alloc_tag     (bus.alloc_tag),
        .ckpt_full     (bus.ckpt_full),
        .restore_head  (restore_head)
    );

    assign bus.ready       = run;
    assign bus.alloc_grant = grant;
    assign bus.num_free    = num_free;
    assign bus.alloc_preg1 = list_mem[head_idx];
    assign bus.alloc_preg2 = list_mem[head_idx + preg_t'(1)];

    a_no_overfill: assert property (@(posedge clk) disable iff (!reset_n)
        num_free <= ptr_t'(NUM_PREGS - NUM_AREGS));

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Directed bench for preg_alloc_ctrl: fill, reset mid-run, checkpoints, exhaustion and frees.
module tb_preg_alloc_ctrl;
    import preg_alloc_ctrl_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;
    int   cyc;

    preg_alloc_ctrl_if bus ();

    preg_alloc_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic br, input logic [1:0] fv,
                         input int f1, input int f2, input logic res, input logic sd,
                         input int tag);
        bus.alloc_req     = req;
        bus.alloc_branch  = br;
        bus.free_valid    = fv;
        bus.free_preg1    = preg_t'(f1);
        bus.free_preg2    = preg_t'(f2);
        bus.resolve       = res;
        bus.shootdown     = sd;
        bus.shootdown_tag = branch_tag_t'(tag);
        #1;
    endtask

    task automatic idle();
        drive(2'd0, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!bus.ready && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        idle();
        #11;
        check("rst_ready",     bus.ready,       0);
        check("rst_grant",     bus.alloc_grant, 0);
        check("rst_num_free",  bus.num_free,    0);
        check("rst_ckpt_full", bus.ckpt_full,   0);
        check("rst_tag",       bus.alloc_tag,   0);

        // Fill sequence
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(cyc);
        check("init_cycles",   cyc,             24);
        check("init_num_free", bus.num_free,    48);
        check("init_preg1",    bus.alloc_preg1, 16);
        check("init_preg2",    bus.alloc_preg2, 17);

        // Advance head to 10, then reset mid-run
        for (int k = 0; k < 5; k++) begin
            drive(2'd2, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
            check("run_grant", bus.alloc_grant, 1);
            check("run_preg1", bus.alloc_preg1, 16 + 2 * k);
            tick();
        end
        check("head10_num_free", bus.num_free,    38);
        check("head10_preg1",    bus.alloc_preg1, 26);
        drive(2'd2, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready",    bus.ready,       0);
        check("mid_rst_grant",    bus.alloc_grant, 0);
        check("mid_rst_num_free", bus.num_free,    0);
        check("mid_rst_tag",      bus.alloc_tag,   0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready(cyc);
        check("reinit_cycles",   cyc,             24);
        check("reinit_num_free", bus.num_free,    48);
        check("reinit_preg1",    bus.alloc_preg1, 16);
        check("reinit_preg2",    bus.alloc_preg2, 17);

        // Branch checkpoint at head=4 then shootdown (with a slot-1-only free)
        drive(2'd2, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        tick();
        tick();
        drive(2'd2, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        check("br_grant", bus.alloc_grant, 1);
        check("br_tag",   bus.alloc_tag,   0);
        check("br_preg1", bus.alloc_preg1, 20);
        check("br_preg2", bus.alloc_preg2, 21);
        tick();
        idle();
        check("br_next_tag",  bus.alloc_tag, 1);
        check("br_num_free",  bus.num_free,  42);
        drive(2'd2, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        tick();
        tick();
        tick();
        check("pre_sd_num_free", bus.num_free, 36);
        drive(2'd0, 1'b0, 2'b10, 0, 5, 1'b0, 1'b1, 0);
        check("sd_no_grant", bus.alloc_grant, 0);
        tick();
        idle();
        check("sd_preg1",    bus.alloc_preg1, 22);
        check("sd_num_free", bus.num_free,    43);
        check("sd_tag",      bus.alloc_tag,   0);

        // Fill all checkpoints, refuse, resolve, wrap
        for (int k = 0; k < 4; k++) begin
            drive(2'd0, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0, 0);
            check("ck_grant", bus.alloc_grant, 1);
            check("ck_tag",   bus.alloc_tag,   k);
            tick();
        end
        drive(2'd0, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        check("ck_full",    bus.ckpt_full,   1);
        check("ck_refused", bus.alloc_grant, 0);
        tick();
        drive(2'd0, 1'b0, 2'b00, 0, 0, 1'b1, 1'b0, 0);
        tick();
        idle();
        check("ck_after_resolve_full", bus.ckpt_full, 0);
        drive(2'd0, 1'b1, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        check("ck_wrap_grant", bus.alloc_grant, 1);
        check("ck_wrap_tag",   bus.alloc_tag,   0);
        tick();
        idle();
        check("ck_full_again", bus.ckpt_full, 1);
        // Resolve oldest (tag 1) and shoot down tag 3 together
        drive(2'd0, 1'b0, 2'b00, 0, 0, 1'b1, 1'b1, 3);
        tick();
        idle();
        check("rs_sd_full",     bus.ckpt_full, 0);
        check("rs_sd_tag",      bus.alloc_tag, 3);
        check("rs_sd_num_free", bus.num_free,  43);
        check("rs_sd_preg1",    bus.alloc_preg1, 22);

        // Drain the list in order
        for (int k = 0; k < 21; k++) begin
            drive(2'd2, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
            check("drain_grant", bus.alloc_grant, 1);
            check("drain_preg1", bus.alloc_preg1, 22 + 2 * k);
            check("drain_preg2", bus.alloc_preg2, 23 + 2 * k);
            tick();
        end
        idle();
        check("drain_num_free", bus.num_free,    1);
        check("drain_last",     bus.alloc_preg1, 5);

        // Alloc refused while frees land the same cycle
        drive(2'd2, 1'b0, 2'b11, 7, 9, 1'b0, 1'b0, 0);
        check("short_no_grant", bus.alloc_grant, 0);
        tick();
        idle();
        check("after_free_num_free", bus.num_free, 3);
        drive(2'd2, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        check("refill_grant", bus.alloc_grant, 1);
        check("refill_preg1", bus.alloc_preg1, 5);
        check("refill_preg2", bus.alloc_preg2, 7);
        tick();
        drive(2'd1, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        check("single_grant", bus.alloc_grant, 1);
        check("single_preg1", bus.alloc_preg1, 9);
        tick();
        idle();
        check("empty_num_free", bus.num_free, 0);
        drive(2'd1, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        check("empty_no_grant", bus.alloc_grant, 0);
        drive(2'd0, 1'b0, 2'b00, 0, 0, 1'b0, 1'b0, 0);
        check("empty_zero_req_grant", bus.alloc_grant, 1);
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
